// File: rtl/camera_power_seq_if.sv
// -----------------------------------------------------------------------------
// camera_power_seq_if
//
// Bundles the sequencer's control and pin signals so the sequencer, the board
// top level and the testbench all share one definition.
//
// Signals:
//   enable      level, 1 = bring the sensor up, 0 = power it down
//   pll_lock    lock from the camera PLL (asynchronous to the board clock)
//   pll_reset   active-high reset to the camera PLL
//   xclk_en     enable for the XCLK output gate/ODDR
//   cam_pwdn    sensor power-down, active high
//   cam_rst_n   sensor reset, active low
//   init_start  one-cycle pulse to the SCCB register-init block
//   ready       high while the sensor is up and initialisable
//   state_dbg   current sequencer state encoding, debug only
//
// Modports:
//   master  system side: drives enable/pll_lock, observes the sequencer
//   slave   the sequencer itself
// -----------------------------------------------------------------------------
interface camera_power_seq_if;
    logic       enable;
    logic       pll_lock;
    logic       pll_reset;
    logic       xclk_en;
    logic       cam_pwdn;
    logic       cam_rst_n;
    logic       init_start;
    logic       ready;
    logic [2:0] state_dbg;

    modport master (
        output enable,
        output pll_lock,
        input  pll_reset,
        input  xclk_en,
        input  cam_pwdn,
        input  cam_rst_n,
        input  init_start,
        input  ready,
        input  state_dbg
    );

    modport slave (
        input  enable,
        input  pll_lock,
        output pll_reset,
        output xclk_en,
        output cam_pwdn,
        output cam_rst_n,
        output init_start,
        output ready,
        output state_dbg
    );
endinterface

// File: rtl/camera_power_seq.sv
// -----------------------------------------------------------------------------
// camera_power_seq
//
// Power-up and reset sequencer for the image sensor. Runs on the free-running
// 50 MHz board clock (never on the PLL output, which is unusable until lock).
// Waits for a stable PLL lock, gates XCLK on, then walks the sensor's PWDN and
// RESET pins through timed phases and finally fires a one-cycle start pulse to
// the SCCB register-init block. If lock never arrives the PLL is pulsed into
// reset and the wait retried; if lock is lost later the sensor is dropped back
// to its power-down pin levels and the sequence restarts.
//
// Ports:
//   clk    50 MHz board clock
//   rst_n  asynchronous active-low reset
//   bus    camera_power_seq_if.slave: enable/pll_lock in, PLL and sensor pin
//          controls, init_start, ready and state_dbg out
//
// Timing: one shared counter is cleared on every state entry and counts the
// cycles spent in a timed state; a phase of N cycles ends when cnt == N-1.
// All outputs are registered and decoded from the next state, so every pin
// change lines up with the state entry that causes it.
// -----------------------------------------------------------------------------
module camera_power_seq #(
    parameter int unsigned CNT_W            = 24,
    parameter int unsigned LOCK_TIMEOUT_CYC = 500000,  // 10 ms
    parameter int unsigned PLL_RST_CYC      = 64,
    parameter int unsigned LOCK_STABLE_CYC  = 1024,
    parameter int unsigned PWDN_CYC         = 50000,   // 1 ms
    parameter int unsigned RST_CYC          = 50000,   // 1 ms
    parameter int unsigned SETTLE_CYC       = 1000000  // 20 ms
) (
    input  logic               clk,
    input  logic               rst_n,
    camera_power_seq_if.slave  bus
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks: every phase must be at least one
    // cycle long and must fit in the counter range.
    // -------------------------------------------------------------------------
    localparam longint unsigned CNT_SPAN = 64'd1 << CNT_W;

    if (CNT_W < 1 || CNT_W > 32) begin : g_chk_cnt_w
        $error("camera_power_seq: CNT_W must be in 1..32");
    end
    if (LOCK_TIMEOUT_CYC < 1 || 64'(LOCK_TIMEOUT_CYC) > CNT_SPAN) begin : g_chk_timeout
        $error("camera_power_seq: LOCK_TIMEOUT_CYC out of range for CNT_W");
    end
    if (PLL_RST_CYC < 1 || 64'(PLL_RST_CYC) > CNT_SPAN) begin : g_chk_pll_rst
        $error("camera_power_seq: PLL_RST_CYC out of range for CNT_W");
    end
    if (LOCK_STABLE_CYC < 1 || 64'(LOCK_STABLE_CYC) > CNT_SPAN) begin : g_chk_stable
        $error("camera_power_seq: LOCK_STABLE_CYC out of range for CNT_W");
    end
    if (PWDN_CYC < 1 || 64'(PWDN_CYC) > CNT_SPAN) begin : g_chk_pwdn
        $error("camera_power_seq: PWDN_CYC out of range for CNT_W");
    end
    if (RST_CYC < 1 || 64'(RST_CYC) > CNT_SPAN) begin : g_chk_rst
        $error("camera_power_seq: RST_CYC out of range for CNT_W");
    end
    if (SETTLE_CYC < 1 || 64'(SETTLE_CYC) > CNT_SPAN) begin : g_chk_settle
        $error("camera_power_seq: SETTLE_CYC out of range for CNT_W");
    end

    // Terminal counter values: a phase of N cycles ends when cnt == N-1.
    localparam logic [CNT_W-1:0] LAST_TIMEOUT = CNT_W'(LOCK_TIMEOUT_CYC - 32'd1);
    localparam logic [CNT_W-1:0] LAST_PLL_RST = CNT_W'(PLL_RST_CYC - 32'd1);
    localparam logic [CNT_W-1:0] LAST_STABLE  = CNT_W'(LOCK_STABLE_CYC - 32'd1);
    localparam logic [CNT_W-1:0] LAST_PWDN    = CNT_W'(PWDN_CYC - 32'd1);
    localparam logic [CNT_W-1:0] LAST_RST     = CNT_W'(RST_CYC - 32'd1);
    localparam logic [CNT_W-1:0] LAST_SETTLE  = CNT_W'(SETTLE_CYC - 32'd1);

    typedef enum logic [2:0] {
        ST_OFF         = 3'd0,
        ST_WAIT_LOCK   = 3'd1,
        ST_PLL_RST     = 3'd2,
        ST_LOCK_STABLE = 3'd3,
        ST_PWDN_HOLD   = 3'd4,
        ST_RST_HOLD    = 3'd5,
        ST_SETTLE      = 3'd6,
        ST_READY       = 3'd7
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] phase_last;
    logic             timed;
    logic             phase_done;

    logic             lock_meta;
    logic             lock_s;

    logic             pll_reset_q;
    logic             xclk_en_q;
    logic             cam_pwdn_q;
    logic             cam_rst_n_q;
    logic             init_start_q;
    logic             ready_q;

    // -------------------------------------------------------------------------
    // pll_lock comes from another clock domain: two-flop synchroniser. Every
    // decision below uses lock_s, which trails pll_lock by two cycles.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make lock_s take the *old*
            // lock_meta, giving two real flop stages instead of one.
            lock_meta <= bus.pll_lock;
            lock_s    <= lock_meta;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_nxt  = state;
        phase_last = '0;
        timed      = 1'b1;

        case (state)
            ST_WAIT_LOCK:   phase_last = LAST_TIMEOUT;
            ST_PLL_RST:     phase_last = LAST_PLL_RST;
            ST_LOCK_STABLE: phase_last = LAST_STABLE;
            ST_PWDN_HOLD:   phase_last = LAST_PWDN;
            ST_RST_HOLD:    phase_last = LAST_RST;
            ST_SETTLE:      phase_last = LAST_SETTLE;
            default:        timed      = 1'b0;  // OFF and READY are untimed
        endcase

        phase_done = timed && (cnt == phase_last);

        // enable=0 wins over everything; lock loss wins over phase completion.
        if (!bus.enable) begin
            state_nxt = ST_OFF;
        end else begin
            case (state)
                ST_OFF: begin
                    state_nxt = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (lock_s)          state_nxt = ST_LOCK_STABLE;
                    else if (phase_done) state_nxt = ST_PLL_RST;
                end
                ST_PLL_RST: begin
                    if (phase_done) state_nxt = ST_WAIT_LOCK;
                end
                ST_LOCK_STABLE: begin
                    if (!lock_s)         state_nxt = ST_WAIT_LOCK;
                    else if (phase_done) state_nxt = ST_PWDN_HOLD;
                end
                ST_PWDN_HOLD: begin
                    if (!lock_s)         state_nxt = ST_WAIT_LOCK;
                    else if (phase_done) state_nxt = ST_RST_HOLD;
                end
                ST_RST_HOLD: begin
                    if (!lock_s)         state_nxt = ST_WAIT_LOCK;
                    else if (phase_done) state_nxt = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (!lock_s)         state_nxt = ST_WAIT_LOCK;
                    else if (phase_done) state_nxt = ST_READY;
                end
                ST_READY: begin
                    if (!lock_s) state_nxt = ST_WAIT_LOCK;
                end
                default: begin
                    state_nxt = ST_OFF;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State, phase counter and registered pin outputs. Pins are decoded from
    // state_nxt so they change on the same edge the state does; WAIT_LOCK
    // carries OFF-level sensor pins, which is what makes a lock loss drop the
    // sensor back to power-down on the very next edge.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_OFF;
            cnt          <= '0;
            pll_reset_q  <= 1'b0;
            xclk_en_q    <= 1'b0;
            cam_pwdn_q   <= 1'b1;
            cam_rst_n_q  <= 1'b0;
            init_start_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state_nxt != state || !timed) cnt <= '0;
            else                              cnt <= cnt + CNT_W'(1);

            pll_reset_q  <= (state_nxt == ST_PLL_RST);
            xclk_en_q    <= (state_nxt == ST_PWDN_HOLD) || (state_nxt == ST_RST_HOLD) ||
                            (state_nxt == ST_SETTLE)    || (state_nxt == ST_READY);
            cam_pwdn_q   <= (state_nxt == ST_OFF)         || (state_nxt == ST_WAIT_LOCK) ||
                            (state_nxt == ST_PLL_RST)     || (state_nxt == ST_LOCK_STABLE) ||
                            (state_nxt == ST_PWDN_HOLD);
            cam_rst_n_q  <= (state_nxt == ST_SETTLE) || (state_nxt == ST_READY);
            ready_q      <= (state_nxt == ST_READY);
            // Only the entry into READY fires the SCCB init; staying does not.
            init_start_q <= (state_nxt == ST_READY) && (state != ST_READY);
        end
    end

    assign bus.pll_reset  = pll_reset_q;
    assign bus.xclk_en    = xclk_en_q;
    assign bus.cam_pwdn   = cam_pwdn_q;
    assign bus.cam_rst_n  = cam_rst_n_q;
    assign bus.init_start = init_start_q;
    assign bus.ready      = ready_q;
    assign bus.state_dbg  = state;

    // -------------------------------------------------------------------------
    // Sanity properties on the pin outputs
    // -------------------------------------------------------------------------
    a_init_single: assert property (@(posedge clk) disable iff (!rst_n)
        bus.init_start |=> !bus.init_start);

    a_ready_pins: assert property (@(posedge clk) disable iff (!rst_n)
        bus.ready |-> (bus.xclk_en && !bus.cam_pwdn && bus.cam_rst_n));

    a_pll_rst_pins: assert property (@(posedge clk) disable iff (!rst_n)
        bus.pll_reset |-> (bus.cam_pwdn && !bus.xclk_en && !bus.cam_rst_n));

endmodule

// File: tb/tb_camera_power_seq.sv
// -----------------------------------------------------------------------------
// tb_camera_power_seq
//
// Scoreboard bench for camera_power_seq with short phase lengths. A phase-level
// reference model (phase table, duration table, lock delay line) runs on every
// clock edge and pushes each expected change of the output vector, stamped with
// its cycle number, into a queue. An independent monitor samples the DUT on the
// falling edge and, whenever the outputs change, pops and compares the next
// expected change (value and cycle). Expected changes that never show up are
// reported as missing.
// -----------------------------------------------------------------------------
module tb_camera_power_seq;

    localparam int unsigned T_TIMEOUT = 20;
    localparam int unsigned T_PLLRST  = 4;
    localparam int unsigned T_STABLE  = 8;
    localparam int unsigned T_PWDN    = 5;
    localparam int unsigned T_RST     = 6;
    localparam int unsigned T_SETTLE  = 10;

    // Output vector: {pll_reset, xclk_en, cam_pwdn, cam_rst_n, init_start, ready, state_dbg}
    localparam logic [8:0] RESET_VEC = 9'b0_0_1_0_0_0_000;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #10 clk = ~clk;

    camera_power_seq_if bus ();

    camera_power_seq #(
        .CNT_W            (24),
        .LOCK_TIMEOUT_CYC (T_TIMEOUT),
        .PLL_RST_CYC      (T_PLLRST),
        .LOCK_STABLE_CYC  (T_STABLE),
        .PWDN_CYC         (T_PWDN),
        .RST_CYC          (T_RST),
        .SETTLE_CYC       (T_SETTLE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // -------------------------------------------------------------------------
    // Check bookkeeping
    // -------------------------------------------------------------------------
    int unsigned total = 0;
    int unsigned bad   = 0;

    task automatic check(input string name, input bit ok, input string got, input string want);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %s, required %s", name, got, want);
        end
    endtask

    function automatic logic [8:0] dut_vec();
        return {bus.pll_reset, bus.xclk_en, bus.cam_pwdn, bus.cam_rst_n,
                bus.init_start, bus.ready, bus.state_dbg};
    endfunction

    // -------------------------------------------------------------------------
    // Reference model: phases in the order the sequence walks them.
    // -------------------------------------------------------------------------
    localparam int P_OFF = 0, P_WAIT = 1, P_PLLRST = 2, P_STABLE = 3,
                   P_PWDN = 4, P_RST = 5, P_SETTLE = 6, P_READY = 7;

    // Pin levels per phase: {pll_reset, xclk_en, cam_pwdn, cam_rst_n, ready}
    logic [4:0]  pin_tab [8] = '{5'b00100, 5'b00100, 5'b10100, 5'b00100,
                                 5'b01100, 5'b01000, 5'b01010, 5'b01011};
    int unsigned dur_tab [8] = '{0, T_TIMEOUT, T_PLLRST, T_STABLE,
                                 T_PWDN, T_RST, T_SETTLE, 0};

    int          m_phase = P_OFF;
    int unsigned m_spent = 0;
    bit          m_init  = 1'b0;
    bit          sync_q[$] = '{1'b0, 1'b0};   // {lock_s, first sync stage}
    int unsigned cyc     = 0;

    typedef struct {
        int unsigned cyc;
        logic [8:0]  vec;
        logic [8:0]  prev;
    } ev_t;

    ev_t        exp_q[$];
    logic [8:0] last_exp = RESET_VEC;

    function automatic logic [8:0] model_vec();
        logic [4:0] p;
        p = pin_tab[m_phase];
        return {p[4:1], m_init, p[0], 3'(m_phase)};
    endfunction

    function automatic void model_reset();
        m_phase = P_OFF;
        m_spent = 0;
        m_init  = 1'b0;
        sync_q  = '{1'b0, 1'b0};
    endfunction

    function automatic void model_edge();
        bit ls;
        int nxt;
        ls = sync_q[0];
        void'(sync_q.pop_front());
        sync_q.push_back(bus.pll_lock);
        m_spent++;
        nxt = m_phase;
        if (!bus.enable) begin
            nxt = P_OFF;
        end else begin
            case (m_phase)
                P_OFF:    nxt = P_WAIT;
                P_WAIT:   if (ls) nxt = P_STABLE;
                          else if (m_spent == dur_tab[P_WAIT]) nxt = P_PLLRST;
                P_PLLRST: if (m_spent == dur_tab[P_PLLRST]) nxt = P_WAIT;
                P_READY:  if (!ls) nxt = P_WAIT;
                default:  if (!ls) nxt = P_WAIT;   // lock-watched timed phases
                          else if (m_spent == dur_tab[m_phase]) nxt = m_phase + 1;
            endcase
        end
        m_init = (nxt == P_READY) && (m_phase != P_READY);
        if (nxt != m_phase) m_spent = 0;
        m_phase = nxt;
    endfunction

    // Record an expected output change; two updates inside one cycle (a clock
    // edge followed by an async reset) merge into the single change the
    // monitor will see.
    function automatic void publish();
        logic [8:0] v;
        ev_t        e;
        v = model_vec();
        if (exp_q.size() > 0 && exp_q[$].cyc == cyc) begin
            e = exp_q.pop_back();
            if (v != e.prev) begin
                e.vec = v;
                exp_q.push_back(e);
            end
        end else if (v != last_exp) begin
            exp_q.push_back('{cyc: cyc, vec: v, prev: last_exp});
        end
        last_exp = v;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) model_reset();
            else        model_edge();
            publish();
        end
    end

    initial begin
        forever begin
            @(negedge rst_n);
            model_reset();
            publish();
        end
    end

    // -------------------------------------------------------------------------
    // Monitor: compare every observed output change against the scoreboard.
    // -------------------------------------------------------------------------
    logic [8:0] last_dut = RESET_VEC;

    initial begin
        logic [8:0] v;
        ev_t        e;
        forever begin
            @(negedge clk);
            v = dut_vec();
            if (v !== last_dut) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_change", 1'b0,
                          $sformatf("%b at cycle %0d", v, cyc), "no change");
                end else begin
                    e = exp_q.pop_front();
                    check("pin_event", (v === e.vec) && (cyc == e.cyc),
                          $sformatf("%b at cycle %0d", v, cyc),
                          $sformatf("%b at cycle %0d", e.vec, e.cyc));
                end
                last_dut = v;
            end
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                check("missing_event", 1'b0,
                      $sformatf("%b at cycle %0d", v, cyc),
                      $sformatf("%b at cycle %0d", e.vec, e.cyc));
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget);
        int n;
        n = 0;
        while (bus.state_dbg !== target && n < budget) begin
            tick(1);
            n++;
        end
        check($sformatf("reach_state_%0d", target), bus.state_dbg === target,
              $sformatf("%0d", bus.state_dbg), $sformatf("%0d", target));
    endtask

    // Asserts rst_n between clock edges and confirms the outputs snap to
    // their reset levels without waiting for a clock edge.
    task automatic pulse_reset(input int n);
        rst_n = 1'b0;
        #1;
        check("async_reset", dut_vec() === RESET_VEC,
              $sformatf("%b", dut_vec()), $sformatf("%b", RESET_VEC));
        tick(n);
        rst_n = 1'b1;
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        bus.enable   = 1'b0;
        bus.pll_lock = 1'b0;
        #1;
        pulse_reset(3);

        // Nominal bring-up with lock present from the start.
        bus.enable   = 1'b1;
        bus.pll_lock = 1'b1;
        wait_state(3'd7, 60);
        tick(5);

        // Lock loss while READY, then relock: full sequence and a new init pulse.
        bus.pll_lock = 1'b0;
        tick($urandom_range(1, 4));
        bus.pll_lock = 1'b1;
        wait_state(3'd7, 80);
        tick(3);

        // Lock never arrives: repeated timeouts and PLL reset pulses.
        bus.enable   = 1'b0;
        bus.pll_lock = 1'b0;
        tick(2);
        bus.enable = 1'b1;
        tick(3 * (T_TIMEOUT + T_PLLRST) + $urandom_range(0, 10));
        // Drop enable inside a PLL reset pulse: pll_reset must fall at once.
        wait_state(3'd2, 40);
        tick($urandom_range(0, 2));
        bus.enable = 1'b0;
        tick(3);

        // One-cycle lock glitch inside the stability window.
        bus.enable   = 1'b1;
        bus.pll_lock = 1'b1;
        wait_state(3'd3, 40);
        tick(3);
        bus.pll_lock = 1'b0;
        tick(1);
        bus.pll_lock = 1'b1;
        wait_state(3'd7, 80);

        // enable drop in RST_HOLD, then an async reset during SETTLE.
        wait_state(3'd7, 5);
        bus.enable = 1'b0;
        tick(2);
        bus.enable = 1'b1;
        wait_state(3'd5, 80);
        tick(2);
        bus.enable = 1'b0;
        tick(2);
        bus.enable = 1'b1;
        wait_state(3'd6, 80);
        tick(3);
        pulse_reset(2);
        wait_state(3'd7, 80);

        // Random soak: enable/lock toggles and occasional async resets.
        for (int i = 0; i < 1500; i++) begin
            if (bus.enable) begin
                if ($urandom_range(0, 149) == 0) bus.enable = 1'b0;
            end else if ($urandom_range(0, 4) == 0) begin
                bus.enable = 1'b1;
            end
            if (bus.pll_lock) begin
                if ($urandom_range(0, 59) == 0) bus.pll_lock = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                bus.pll_lock = 1'b1;
            end
            if ($urandom_range(0, 299) == 0) pulse_reset($urandom_range(1, 3));
            else                             tick(1);
        end

        tick(4);
        check("scoreboard_drained", exp_q.size() == 0,
              $sformatf("%0d pending", exp_q.size()), "0 pending");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
